// File: rtl/cla_slice_sequencer.sv
// -----------------------------------------------------------------------------
// cla_slice_sequencer
//
// Multi-cycle wide adder. A single 4-bit carry-lookahead slice is stepped over
// a WIDTH-bit operand pair, least-significant nibble first, one nibble per
// clock. Valid/ready handshakes sit on both the operand and the result side.
//
// Parameters:
//   WIDTH      operand/sum width; a multiple of 4 and >= 4 (NSLICE = WIDTH/4)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   block can accept operands (IDLE)
//   a, b, cin  operands and carry into bit 0, sampled only at the accept edge
//   busy       slice processing in progress (RUN)
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   sum        (a + b + cin) mod 2^WIDTH, valid while out_valid=1
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow of the final nibble (only with CLA_SEQ_OVF_EN)
//
// Optional feature macro: CLA_SEQ_OVF_EN adds the ovf port and its register.
// -----------------------------------------------------------------------------
module cla_slice_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSLICE = WIDTH / 4;
   localparam int KW     = $clog2(NSLICE + 1);
   localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [KW-1:0]    k_q;
   logic             cr_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             cout_q;
   logic             out_valid_q;
   logic             busy_q;
   logic             in_ready_q;
`ifdef CLA_SEQ_OVF_EN
   logic             ovf_q;
`endif

   // Lookahead slice. The operand registers are shifted right by one nibble
   // per RUN cycle, so the active nibble is always at bits [3:0].
   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] s;
   logic       c0, c1, c2, c3;

   always_comb begin
      p  = a_q[3:0] ^ b_q[3:0];
      g  = a_q[3:0] & b_q[3:0];
      // Carries are fully expanded in (p, g, cr) rather than chained.
      c0 = g[0] | (p[0] & cr_q);
      c1 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cr_q);
      c2 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cr_q);
      c3 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cr_q);
      s  = p ^ {c2, c1, c0, cr_q};
   end

   // Drop the slice result into nibble k; higher nibbles keep stale data.
   always_comb begin
      sum_d = sum_q;
      for (int i = 0; i < NSLICE; i++) begin
         if (k_q == KW'(i)) begin
            sum_d[4*i +: 4] = s;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         cr_q        <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         // in_ready rises on the first edge after reset is released.
         in_ready_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b;
                  cr_q       <= cin;
                  k_q        <= '0;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               sum_q <= sum_d;
               cr_q  <= c3;
               a_q   <= a_q >> 4;
               b_q   <= b_q >> 4;
               if (k_q == KLAST) begin
                  cout_q      <= c3;
`ifdef CLA_SEQ_OVF_EN
                  ovf_q       <= c3 ^ c2;
`endif
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            DONE: begin
               // in_ready stays low here, so an in_valid coinciding with
               // out_ready is only taken in the following IDLE cycle.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef CLA_SEQ_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule
